// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, requester ids and an ack decode helper.
package sram_arb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } owner_e;

  // Bit order {dma, cpu, vid}, matching the ack outputs.
  function automatic logic [2:0] owner_onehot(input owner_e owner);
    logic [2:0] onehot;
    onehot = 3'b000;
    unique case (owner)
      OWN_VID: onehot = 3'b001;
      OWN_CPU: onehot = 3'b010;
      OWN_DMA: onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational requester picker: video first, then CPU/DMA by round-robin bit.
// With SRAM_DMA_PORT_EN undefined the DMA request and rr bit are ignored.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   rr,
  output logic   valid,
  output owner_e owner
);

  always_comb begin
    valid = 1'b1;
    owner = OWN_VID;
    if (vid_req) begin
      owner = OWN_VID;
`ifdef SRAM_DMA_PORT_EN
    end else if (cpu_req && dma_req) begin
      owner = rr ? OWN_DMA : OWN_CPU;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end else if (dma_req) begin
      owner = OWN_DMA;
`else
    end else if (cpu_req) begin
      owner = OWN_CPU;
`endif
    end else begin
      valid = 1'b0;
    end
  end

`ifndef SRAM_DMA_PORT_EN
  logic w_unused_pick;
  assign w_unused_pick = dma_req ^ rr;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Sequences video/CPU/DMA accesses onto one asynchronous 8-bit SRAM bus (setup, strobe, recovery).
// Define SRAM_DMA_PORT_EN to enable the DMA port; otherwise only video and CPU are served.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW            = 21,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vid_req,
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic [AW-1:0] vid_addr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] dma_addr,
  input  logic          cpu_we,
  input  logic          dma_we,
  input  logic [7:0]    cpu_wdata,
  input  logic [7:0]    dma_wdata,
  output logic          vid_ack,
  output logic          cpu_ack,
  output logic          dma_ack,
  output logic [7:0]    rdata,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  output logic          sram_doe,
  input  logic [7:0]    sram_din,
  output logic          sram_we_n
);

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  owner_e        r_owner;
  logic          r_we;
  logic [2:0]    r_ack;
  logic [7:0]    r_rdata;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_dout;
  logic          r_doe;
  logic          r_we_n;

  logic          w_rr;
  logic          w_valid;
  owner_e        w_owner;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [7:0]    w_wdata;

  sram_arb_pick u_pick (
    .vid_req (vid_req),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .rr      (w_rr),
    .valid   (w_valid),
    .owner   (w_owner)
  );

  // Video is read-only, so its write flag and data stay at zero.
  always_comb begin
    w_addr  = vid_addr;
    w_we    = 1'b0;
    w_wdata = 8'h00;
    unique case (w_owner)
      OWN_CPU: begin
        w_addr  = cpu_addr;
        w_we    = cpu_we;
        w_wdata = cpu_wdata;
      end
`ifdef SRAM_DMA_PORT_EN
      OWN_DMA: begin
        w_addr  = dma_addr;
        w_we    = dma_we;
        w_wdata = dma_wdata;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_owner <= OWN_VID;
      r_we    <= 1'b0;
      r_ack   <= 3'b000;
      r_rdata <= 8'h00;
      r_addr  <= '0;
      r_dout  <= 8'h00;
      r_doe   <= 1'b0;
      r_we_n  <= 1'b1;
    end else begin
      r_ack <= 3'b000;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_owner;
            r_addr  <= w_addr;
            r_we    <= w_we;
            if (w_we) begin
              r_dout <= w_wdata;
              r_doe  <= 1'b1;
              r_we_n <= 1'b0;
            end
            r_cnt   <= CNT_INIT;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              r_rdata <= sram_din;
            end
            r_we_n  <= 1'b1;
            r_ack   <= owner_onehot(r_owner);
            r_state <= RECOVER;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RECOVER: begin
          // Address and data stay put for one cycle of hold after the strobe rises.
          r_doe   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_DMA_PORT_EN
  logic r_rr;

  // Point at the other port after every CPU or DMA grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= 1'b0;
    end else if (r_state == IDLE && w_valid && w_owner != OWN_VID) begin
      r_rr <= (w_owner == OWN_CPU);
    end
  end

  assign w_rr    = r_rr;
  assign dma_ack = r_ack[2];
`else
  logic w_unused_dma;

  assign w_rr         = 1'b0;
  assign dma_ack      = 1'b0;
  assign w_unused_dma = ^{dma_addr, dma_we, dma_wdata, r_ack[2]};
`endif

  assign vid_ack   = r_ack[0];
  assign cpu_ack   = r_ack[1];
  assign rdata     = r_rdata;
  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign sram_doe  = r_doe;
  assign sram_we_n = r_we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed steps plus random traffic against a
// transaction-level reference model; extra instances cover ACCESS_CYCLES = 1 and 15.
module tb_sram_arbiter;

  localparam int AC = 2;
`ifdef SRAM_DMA_PORT_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Requesters: index 0 = video, 1 = cpu, 2 = dma.
  logic        rq    [3];
  logic [20:0] ra    [3];
  logic        rw    [3];
  logic [7:0]  rd    [3];
  bit          renew [3];
  bit          rnd   [3];

  logic        vid_ack, cpu_ack, dma_ack, sram_doe, sram_we_n;
  logic [7:0]  rdata, sram_dout, sram_din;
  logic [20:0] sram_addr;

  sram_arbiter #(.AW(21), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .vid_req(rq[0]), .cpu_req(rq[1]), .dma_req(rq[2]),
    .vid_addr(ra[0]), .cpu_addr(ra[1]), .dma_addr(ra[2]),
    .cpu_we(rw[1]), .dma_we(rw[2]), .cpu_wdata(rd[1]), .dma_wdata(rd[2]),
    .vid_ack(vid_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack), .rdata(rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .sram_we_n(sram_we_n)
  );

  // Latency/period instances: CPU-only reads, constant read data.
  logic        s1_req, s15_req, s1_ack, s15_ack;
  logic        s1_vack, s1_dack, s1_doe, s1_wen, s15_vack, s15_dack, s15_doe, s15_wen;
  logic [7:0]  s1_rdata, s15_rdata, s1_dout, s15_dout;
  logic [20:0] s1_addr, s15_addr;

  sram_arbiter #(.AW(21), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .vid_req(1'b0), .cpu_req(s1_req), .dma_req(1'b0),
    .vid_addr(21'h0), .cpu_addr(21'h00123), .dma_addr(21'h0),
    .cpu_we(1'b0), .dma_we(1'b0), .cpu_wdata(8'h00), .dma_wdata(8'h00),
    .vid_ack(s1_vack), .cpu_ack(s1_ack), .dma_ack(s1_dack), .rdata(s1_rdata),
    .sram_addr(s1_addr), .sram_dout(s1_dout), .sram_doe(s1_doe),
    .sram_din(8'h3C), .sram_we_n(s1_wen)
  );

  sram_arbiter #(.AW(21), .ACCESS_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .vid_req(1'b0), .cpu_req(s15_req), .dma_req(1'b0),
    .vid_addr(21'h0), .cpu_addr(21'h00456), .dma_addr(21'h0),
    .cpu_we(1'b0), .dma_we(1'b0), .cpu_wdata(8'h00), .dma_wdata(8'h00),
    .vid_ack(s15_vack), .cpu_ack(s15_ack), .dma_ack(s15_dack), .rdata(s15_rdata),
    .sram_addr(s15_addr), .sram_dout(s15_dout), .sram_doe(s15_doe),
    .sram_din(8'h3C), .sram_we_n(s15_wen)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one transaction in flight, next grant AC+2 edges after the last.
  int          edge_n;
  int          m_grant_e, m_free_e, m_owner;
  logic [20:0] m_addr;
  bit          m_we, m_cpu_turn;
  logic [7:0]  m_wdata, m_last_wdata, m_rdata;
  logic [7:0]  m_mem   [logic [20:0]];
  logic [7:0]  env_mem [logic [20:0]];

  logic [2:0]  obs_ack;
  int          n_we_low, n_doe_hi;
  int          log_port[$];
  int          log_edge[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h96;
  endfunction

  function automatic logic [7:0] m_read(input logic [20:0] a);
    return m_mem.exists(a) ? m_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] env_read(input logic [20:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  task automatic new_txn(input int p);
    ra[p] = 21'($urandom);
    rw[p] = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    rd[p] = 8'($urandom);
    rq[p] = 1'b1;
  endtask

  task automatic model_reset();
    m_grant_e    = -1000;
    m_free_e     = edge_n;
    m_owner      = 0;
    m_addr       = '0;
    m_we         = 1'b0;
    m_wdata      = 8'h00;
    m_last_wdata = 8'h00;
    m_rdata      = 8'h00;
    m_cpu_turn   = 1'b1;
  endtask

  // One clock: advance the model on the edge, compare every registered output, then react.
  task automatic step();
    int         d;
    int         win;
    logic [2:0] exp_ack;
    @(posedge clk);
    edge_n++;
    d       = edge_n - m_grant_e;
    exp_ack = 3'b000;
    if (d == AC) begin
      exp_ack = 3'(1 << m_owner);
      if (m_we) m_mem[m_addr] = m_wdata;
      else      m_rdata = m_read(m_addr);
    end
    if (edge_n >= m_free_e) begin
      win = -1;
      if (rq[0])                        win = 0;
      else if (rq[1] && rq[2] && DMA_EN) win = m_cpu_turn ? 1 : 2;
      else if (rq[1])                   win = 1;
      else if (rq[2] && DMA_EN)         win = 2;
      if (win >= 0) begin
        m_grant_e = edge_n;
        m_free_e  = edge_n + AC + 2;
        m_owner   = win;
        m_addr    = ra[win];
        m_we      = (win != 0) && rw[win];
        m_wdata   = rd[win];
        if (m_we) m_last_wdata = rd[win];
        if (win == 1) m_cpu_turn = 1'b0;
        if (win == 2) m_cpu_turn = 1'b1;
        d = 0;
      end
    end
    #1;
    obs_ack = {dma_ack, cpu_ack, vid_ack};
    chk("ack", obs_ack, exp_ack);
    chk("we_n", sram_we_n, !(m_we && d < AC));
    chk("doe", sram_doe, m_we && d <= AC);
    chk("addr", sram_addr, m_addr);
    chk("dout", sram_dout, m_last_wdata);
    chk("rdata", rdata, m_rdata);
    if (!sram_we_n) env_mem[sram_addr] = sram_dout;
    sram_din = env_read(sram_addr);
    if (!sram_we_n) n_we_low++;
    if (sram_doe) n_doe_hi++;
    for (int p = 0; p < 3; p++) begin
      if (obs_ack[p]) begin
        log_port.push_back(p);
        log_edge.push_back(edge_n);
      end
      if (exp_ack[p]) begin
        if (renew[p] || (rnd[p] && $urandom_range(0, 1) == 1)) new_txn(p);
        else rq[p] = 1'b0;
      end else if (!rq[p] && rnd[p] && $urandom_range(0, 3) == 0) begin
        new_txn(p);
      end
    end
  endtask

  task automatic wait_ack(input int p, input int maxn, output int ae);
    bit found;
    found = 1'b0;
    ae    = -1;
    for (int i = 0; i < maxn && !found; i++) begin
      step();
      if (obs_ack[p]) begin
        found = 1'b1;
        ae    = edge_n;
      end
    end
    chk("wait_ack", found, 1);
  endtask

  initial begin
    int g;
    int ae;
    int nexp;
    bit e1, e15;
    rst     = 1'b1;
    s1_req  = 1'b0;
    s15_req = 1'b0;
    for (int p = 0; p < 3; p++) begin
      rq[p] = 1'b0; ra[p] = '0; rw[p] = 1'b0; rd[p] = 8'h00;
      renew[p] = 1'b0; rnd[p] = 1'b0;
    end
    edge_n = 0;
    model_reset();
    m_mem[21'h1ABCD]   = 8'h5A;
    env_mem[21'h1ABCD] = 8'h5A;
    sram_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {dma_ack, cpu_ack, vid_ack}, 3'b000);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_doe", sram_doe, 1'b0);
    chk("rst_addr", sram_addr, 21'h0);
    chk("rst_dout", sram_dout, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    rst = 1'b0;
    sram_din = env_read(sram_addr);
    step();

    // CPU read of a preloaded location.
    ra[1] = 21'h1ABCD; rw[1] = 1'b0; rq[1] = 1'b1;
    g = edge_n + 1; n_we_low = 0;
    wait_ack(1, 10, ae);
    chk("t1_latency", ae - g, 2);
    chk("t1_rdata", rdata, 8'h5A);
    chk("t1_we_low", n_we_low, 0);
    step(); step();

    // CPU write: strobe width, drive window, stored byte.
    ra[1] = 21'h00010; rw[1] = 1'b1; rd[1] = 8'hC3; rq[1] = 1'b1;
    g = edge_n + 1; n_we_low = 0; n_doe_hi = 0;
    wait_ack(1, 10, ae);
    step(); step();
    chk("t2_latency", ae - g, 2);
    chk("t2_we_low", n_we_low, 2);
    chk("t2_doe_hi", n_doe_hi, 3);
    chk("t2_mem", env_read(21'h00010), 8'hC3);

    // All three at once, then CPU and DMA held.
    ra[0] = 21'h00100; ra[1] = 21'h00200; ra[2] = 21'h00300;
    rw[1] = 1'b0; rw[2] = 1'b0;
    rq[0] = 1'b1; rq[1] = 1'b1; rq[2] = 1'b1;
    g = edge_n + 1;
    log_port.delete(); log_edge.delete();
    repeat (16) step();
    nexp = DMA_EN ? 3 : 2;
    chk("t3_count", log_port.size(), nexp);
    for (int i = 0; i < log_port.size() && i < 3; i++) begin
      chk("t3_port", log_port[i], i);
      chk("t3_edge", log_edge[i], g + 2 + 4 * i);
    end
    rq[1] = 1'b1; rq[2] = 1'b1; renew[1] = 1'b1; renew[2] = 1'b1;
    g = edge_n + 1;
    log_port.delete(); log_edge.delete();
    repeat (12) step();
    chk("t4_count", log_port.size(), 3);
    for (int i = 0; i < log_port.size() && i < 3; i++) begin
      chk("t4_port", log_port[i], (DMA_EN && (i % 2 == 1)) ? 2 : 1);
      chk("t4_edge", log_edge[i], g + 2 + 4 * i);
    end
    renew[1] = 1'b0; renew[2] = 1'b0;
    repeat (20) step();
    if (!DMA_EN) rq[2] = 1'b0;

    // Random traffic on all ports.
    rnd[0] = 1'b1; rnd[1] = 1'b1; rnd[2] = 1'b1;
    repeat (600) step();
    rnd[0] = 1'b0; rnd[1] = 1'b0; rnd[2] = 1'b0;
    if (!DMA_EN) rq[2] = 1'b0;
    repeat (30) step();

    // Reset while the write strobe is low.
    ra[1] = 21'h1F00F; rw[1] = 1'b1; rd[1] = 8'h77; rq[1] = 1'b1;
    step(); step();
    chk("t5_strobe_low", sram_we_n, 1'b0);
    #2;
    rst   = 1'b1;
    rq[1] = 1'b0;
    #1;
    chk("t5_we_n", sram_we_n, 1'b1);
    chk("t5_doe", sram_doe, 1'b0);
    chk("t5_addr", sram_addr, 21'h0);
    chk("t5_dout", sram_dout, 8'h00);
    @(posedge clk);
    #1;
    chk("t5_no_ack", {dma_ack, cpu_ack, vid_ack}, 3'b000);
    rst = 1'b0;
    model_reset();
    sram_din = env_read(sram_addr);
    ra[1] = 21'h00ABC; rw[1] = 1'b0; rq[1] = 1'b1;
    g = edge_n + 1;
    wait_ack(1, 10, ae);
    chk("t5_latency", ae - g, 2);
    chk("t5_rdata", rdata, dflt(21'h00ABC));
    step(); step();

    // ACCESS_CYCLES = 1 and 15 with the CPU request held high.
    s1_req = 1'b1; s15_req = 1'b1;
    for (int n = 1; n <= 52; n++) begin
      step();
      e1  = (n >= 2)  && ((n - 2) % 3 == 0);
      e15 = (n >= 16) && ((n - 16) % 17 == 0);
      chk("ac1_ack", s1_ack, e1);
      chk("ac15_ack", s15_ack, e15);
    end
    chk("ac1_rdata", s1_rdata, 8'h3C);
    chk("ac15_rdata", s15_rdata, 8'h3C);
    s1_req = 1'b0; s15_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
